// File: rtl/ecc_mult_host.sv
// Host-side job controller for the double_and_add scalar multiplier: launches one (k, P, p, a)
// job at a time, bounds its runtime and returns (x3, y3) with status and cycle count.
//
// state  | meaning
// IDLE   | waiting for a job, multiplier held in reset
// LOAD   | operands registered, multiplier reset held for RST_CYC cycles
// RUN    | multiplier released, counting cycles, waiting for done or timeout
// SETTLE | one cycle for the multiplier's x3/y3 registers to update
// OUT    | result presented until the downstream handshake
module ecc_mult_host #(
    parameter int N       = 231,
    parameter int RST_CYC = 2,
    parameter int TMO_W   = 24,
    parameter int MAX_CYC = 2**20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_k,
    input  logic [N-1:0]     in_x,
    input  logic [N-1:0]     in_y,
    input  logic [N-1:0]     in_p,
    input  logic [N-1:0]     in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_x,
    output logic [N-1:0]     out_y,
    output logic [1:0]       out_err,
    output logic [TMO_W-1:0] out_cycles,
    output logic             mul_reset,
    output logic [N-1:0]     mul_p,
    output logic [N-1:0]     mul_c,
    output logic [N-1:0]     mul_x1,
    output logic [N-1:0]     mul_y1,
    output logic [N-1:0]     mul_a,
    input  logic [N-1:0]     mul_x3,
    input  logic [N-1:0]     mul_y3,
    input  logic             mul_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        SETTLE,
        OUT
    } state_t;

    localparam logic [1:0]       ERR_OK   = 2'b00;
    localparam logic [1:0]       ERR_ZERO = 2'b01;
    localparam logic [1:0]       ERR_TMO  = 2'b10;
    localparam logic [TMO_W-1:0] LOAD_LAST = TMO_W'(RST_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(MAX_CYC - 1);

    state_t           state, state_nxt;
    logic [TMO_W-1:0] cnt, cnt_nxt;
    logic [N-1:0]     out_x_nxt, out_y_nxt;
    logic [1:0]       out_err_nxt;
    logic [TMO_W-1:0] out_cycles_nxt;
    logic             accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    // Multiplier stays released through SETTLE so its x3/y3 registers hold the result.
    assign mul_reset = !((state == RUN) || (state == SETTLE));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        out_x_nxt      = out_x;
        out_y_nxt      = out_y;
        out_err_nxt    = out_err;
        out_cycles_nxt = out_cycles;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_k == '0) begin
                        state_nxt      = OUT;
                        out_x_nxt      = '0;
                        out_y_nxt      = '0;
                        out_err_nxt    = ERR_ZERO;
                        out_cycles_nxt = '0;
                    end else begin
                        state_nxt = LOAD;
                        cnt_nxt   = '0;
                    end
                end
            end
            LOAD: begin
                if (cnt == LOAD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                cnt_nxt = cnt + 1'b1;
                // cnt == 0 marks the first RUN cycle, where done is stale.
                if (mul_done && (cnt != '0)) begin
                    state_nxt = SETTLE;
                end else if (cnt == TMO_LAST) begin
                    state_nxt      = OUT;
                    out_x_nxt      = '0;
                    out_y_nxt      = '0;
                    out_err_nxt    = ERR_TMO;
                    out_cycles_nxt = TMO_LAST;
                end
            end
            SETTLE: begin
                state_nxt      = OUT;
                out_x_nxt      = mul_x3;
                out_y_nxt      = mul_y3;
                out_err_nxt    = ERR_OK;
                out_cycles_nxt = cnt;
            end
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_err    <= '0;
            out_cycles <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            out_x      <= out_x_nxt;
            out_y      <= out_y_nxt;
            out_err    <= out_err_nxt;
            out_cycles <= out_cycles_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_p  <= '0;
            mul_c  <= '0;
            mul_x1 <= '0;
            mul_y1 <= '0;
            mul_a  <= '0;
        end else if (accept) begin
            mul_p  <= in_p;
            mul_c  <= in_k;
            mul_x1 <= in_x;
            mul_y1 <= in_y;
            mul_a  <= in_a;
        end
    end

endmodule

// File: tb/tb_ecc_mult_host.sv
// Bench for ecc_mult_host: behavioural multiplier stub on y^2 = x^3 + 2x + 2 over GF(17),
// directed job table plus back-pressure and mid-run reset sequences.
module tb_ecc_mult_host;
    localparam int N       = 8;
    localparam int RST_CYC = 2;
    localparam int TMO_W   = 8;
    localparam int MAX_CYC = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_k = '0, in_x = '0, in_y = '0, in_p = '0, in_a = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_x, out_y;
    logic [1:0]       out_err;
    logic [TMO_W-1:0] out_cycles;
    logic             mul_reset;
    logic [N-1:0]     mul_p, mul_c, mul_x1, mul_y1, mul_a;
    logic [N-1:0]     mul_x3 = 8'hEE, mul_y3 = 8'hEE;
    logic             mul_done;
    logic             busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecc_mult_host #(.N(N), .RST_CYC(RST_CYC), .TMO_W(TMO_W), .MAX_CYC(MAX_CYC)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_k(in_k), .in_x(in_x), .in_y(in_y), .in_p(in_p), .in_a(in_a),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_err(out_err), .out_cycles(out_cycles),
        .mul_reset(mul_reset),
        .mul_p(mul_p), .mul_c(mul_c), .mul_x1(mul_x1), .mul_y1(mul_y1), .mul_a(mul_a),
        .mul_x3(mul_x3), .mul_y3(mul_y3), .mul_done(mul_done),
        .busy(busy)
    );

    // stub modes: 0 real multiplier (done from 6th released cycle), 1 never done,
    // 2 done pulses on 1st and 5th released cycle with distinct result values
    int stub_mode = 0;
    int run_cnt = 0;

    function automatic int md(int v, int p);
        int r = v % p;
        if (r < 0) r += p;
        return r;
    endfunction

    function automatic int inv(int v, int p);
        int r = 1;
        int b = md(v, p);
        int e = p - 2;
        while (e > 0) begin
            if ((e % 2) == 1) r = md(r * b, p);
            b = md(b * b, p);
            e = e / 2;
        end
        return r;
    endfunction

    function automatic logic [2*N-1:0] ec_mul(logic [N-1:0] k, int x, int y, int p, int a);
        int rx = x;
        int ry = y;
        int l, nx;
        int msb = 0;
        for (int i = 0; i < N; i++) if (k[i]) msb = i;
        for (int i = msb - 1; i >= 0; i--) begin
            l  = md((3 * rx * rx + a) * inv(2 * ry, p), p);
            nx = md(l * l - 2 * rx, p);
            ry = md(l * (rx - nx) - ry, p);
            rx = nx;
            if (k[i]) begin
                l  = md((y - ry) * inv(x - rx, p), p);
                nx = md(l * l - rx - x, p);
                ry = md(l * (rx - nx) - ry, p);
                rx = nx;
            end
        end
        return {rx[N-1:0], ry[N-1:0]};
    endfunction

    always_comb begin
        mul_done = 1'b0;
        if (!mul_reset) begin
            if (stub_mode == 0)      mul_done = (run_cnt >= 5);
            else if (stub_mode == 2) mul_done = (run_cnt == 0) || (run_cnt == 4);
        end
    end

    always @(posedge clk) begin
        logic [2*N-1:0] r;
        if (mul_reset) run_cnt <= 0;
        else           run_cnt <= run_cnt + 1;
        if (!mul_reset && mul_done) begin
            if (stub_mode == 0) begin
                r = ec_mul(mul_c, int'(mul_x1), int'(mul_y1), int'(mul_p), int'(mul_a));
                mul_x3 <= r[2*N-1:N];
                mul_y3 <= r[N-1:0];
            end else if (run_cnt == 0) begin
                mul_x3 <= 8'h11;
                mul_y3 <= 8'h22;
            end else begin
                mul_x3 <= 8'h3C;
                mul_y3 <= 8'hC3;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send_job(input logic [N-1:0] k);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_k = k; in_x = 8'd5; in_y = 8'd1; in_p = 8'd17; in_a = 8'd2;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_k = N'($urandom); in_x = N'($urandom); in_y = N'($urandom);
        in_p = N'($urandom); in_a = N'($urandom);
    endtask

    // lat counts cycles from the accept cycle (0) to the first cycle with out_valid
    task automatic wait_out(output int lat, output bit released);
        lat = 1;
        released = !mul_reset;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            if (!mul_reset) released = 1'b1;
        end
        chk("out_valid_seen", out_valid, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
    endtask

    typedef struct {
        logic [N-1:0] k;
        int           mode;
        logic [N-1:0] ex;
        logic [N-1:0] ey;
        logic [1:0]   err;
        int           cyc;
        int           lat;
    } vec_t;

    vec_t vec[8];

    initial begin
        int  lat;
        bit  released;

        vec[0] = '{8'd2, 0, 8'd6,  8'd3,  2'd0, 6,  10};
        vec[1] = '{8'd0, 0, 8'd0,  8'd0,  2'd1, 0,  1};
        vec[2] = '{8'd1, 0, 8'd5,  8'd1,  2'd0, 6,  10};
        vec[3] = '{8'd3, 0, 8'd10, 8'd6,  2'd0, 6,  10};
        vec[4] = '{8'd7, 1, 8'd0,  8'd0,  2'd2, 15, 19};
        vec[5] = '{8'd9, 0, 8'd7,  8'd6,  2'd0, 6,  10};
        vec[6] = '{8'd4, 2, 8'h3C, 8'hC3, 2'd0, 5,  9};
        vec[7] = '{8'd5, 0, 8'd9,  8'd16, 2'd0, 6,  10};

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mul_reset", mul_reset, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_cycles", out_cycles, 0);
        chk("rst_mul_c", mul_c, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            stub_mode = vec[i].mode;
            send_job(vec[i].k);
            wait_out(lat, released);
            chk($sformatf("v%0d_latency", i), lat, vec[i].lat);
            chk($sformatf("v%0d_out_x", i), out_x, vec[i].ex);
            chk($sformatf("v%0d_out_y", i), out_y, vec[i].ey);
            chk($sformatf("v%0d_out_err", i), out_err, vec[i].err);
            chk($sformatf("v%0d_out_cycles", i), out_cycles, vec[i].cyc);
            chk($sformatf("v%0d_mul_c", i), mul_c, vec[i].k);
            chk($sformatf("v%0d_mul_reset_out", i), mul_reset, 1);
            chk($sformatf("v%0d_busy", i), busy, 1);
            if (vec[i].k == 0) chk("k0_never_released", released, 0);
            handshake();
        end

        // back-pressure: result frozen, second job held off until after the handshake
        stub_mode = 0;
        send_job(8'd2);
        wait_out(lat, released);
        in_valid = 1'b1;
        in_k = 8'd3; in_x = 8'd5; in_y = 8'd1; in_p = 8'd17; in_a = 8'd2;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_x", out_x, 6);
            chk("bp_out_y", out_y, 3);
            chk("bp_out_err", out_err, 0);
            chk("bp_out_cycles", out_cycles, 6);
            chk("bp_mul_c", mul_c, 2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_hs_out_valid", out_valid, 0);
        chk("bp_hs_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_busy", busy, 1);
        chk("bp_second_mul_c", mul_c, 3);
        wait_out(lat, released);
        chk("bp_second_out_x", out_x, 10);
        chk("bp_second_out_y", out_y, 6);
        handshake();

        // asynchronous reset in the middle of RUN
        stub_mode = 1;
        send_job(8'd7);
        repeat (4) @(negedge clk);
        chk("mid_run_released", mul_reset, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_mul_reset", mul_reset, 1);
        chk("async_out_valid", out_valid, 0);
        chk("async_in_ready", in_ready, 1);
        chk("async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        stub_mode = 0;
        send_job(8'd5);
        wait_out(lat, released);
        chk("after_rst_latency", lat, 10);
        chk("after_rst_out_x", out_x, 9);
        chk("after_rst_out_y", out_y, 16);
        chk("after_rst_out_err", out_err, 0);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", $time, 200000);
        $fatal(1, "bench timeout");
    end

endmodule
